// File: rtl/sid_bus_arbiter.sv
// sid_bus_arbiter: two-port round-robin arbiter for the voice register write bus,
// plus the CLKEN strobe divider.
// Build option: define SID_ARB_ATOMIC_EN to hold the bus for the writer of a
// frequency/pulse-width low byte until its high byte lands (or a timeout expires).
module sid_bus_arbiter #(
    parameter int unsigned CLK_DIV      = 12,
    parameter int unsigned LOCK_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       A_VALID,
    output logic       A_READY,
    input  logic [4:0] A_ADDR,
    input  logic [7:0] A_DATA,
    input  logic       B_VALID,
    output logic       B_READY,
    input  logic [4:0] B_ADDR,
    input  logic [7:0] B_DATA,
    output logic       CLKEN,
    output logic       WR,
    output logic [4:0] ADDR,
    output logic [7:0] DATA,
    output logic       GRANT,
    output logic       LOCKED
);

    logic [7:0] div_q, div_d;
    logic       clken_q, clken_d;
    logic       div_wrap;

    logic       wr_q, wr_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;  // 1: B was granted last

    logic       a_open, b_open;
    logic       a_rdy, b_rdy;
    logic       acc, sel_b;
    logic [4:0] acc_addr;
    logic [7:0] acc_data;

`ifdef SID_ARB_ATOMIC_EN
    typedef enum logic [1:0] {StOpen, StLockA, StLockB} state_e;
    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;

    // Voice-relative offsets 0 and 2 (freq lo, pw lo) open an atomic pair.
    function automatic logic is_trigger(input logic [4:0] addr);
        case (addr)
            5'd0, 5'd2, 5'd7, 5'd9, 5'd14, 5'd16: is_trigger = 1'b1;
            default:                              is_trigger = 1'b0;
        endcase
    endfunction
`endif

    // Free-running CLKEN divider, independent of bus traffic.
    always_comb begin
        div_wrap = (div_q == 8'(CLK_DIV - 1));
        div_d    = div_wrap ? 8'd0 : div_q + 8'd1;
        clken_d  = div_wrap;
    end

    // Grant selection: round-robin when open, owner-only when locked.
    always_comb begin
        a_open = A_VALID && (!B_VALID || last_q);
        b_open = B_VALID && (!A_VALID || !last_q);
`ifdef SID_ARB_ATOMIC_EN
        a_rdy  = a_open;
        b_rdy  = b_open;
        unique case (state_q)
            StLockA: begin
                a_rdy = A_VALID;
                b_rdy = 1'b0;
            end
            StLockB: begin
                a_rdy = 1'b0;
                b_rdy = B_VALID;
            end
            default: begin
                a_rdy = a_open;
                b_rdy = b_open;
            end
        endcase
`else
        a_rdy  = a_open;
        b_rdy  = b_open;
`endif
        acc      = a_rdy || b_rdy;
        sel_b    = b_rdy;
        acc_addr = sel_b ? B_ADDR : A_ADDR;
        acc_data = sel_b ? B_DATA : A_DATA;
    end

    // Forward the accepted write one cycle later; hold the bus when idle.
    always_comb begin
        wr_d    = acc;
        addr_d  = acc ? acc_addr : addr_q;
        data_d  = acc ? acc_data : data_q;
        grant_d = acc ? sel_b : grant_q;
        last_d  = acc ? sel_b : last_q;
    end

`ifdef SID_ARB_ATOMIC_EN
    // Lock state and timer; an owner accept beats timer expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (acc && is_trigger(acc_addr)) begin
            state_d = sel_b ? StLockB : StLockA;
            timer_d = 8'(LOCK_TIMEOUT);
        end else if (acc && (state_q != StOpen)) begin
            // Only the owner can be accepted while locked.
            state_d = StOpen;
        end else if (state_q != StOpen) begin
            if (timer_q == 8'd1) begin
                state_d = StOpen;
            end else begin
                timer_d = timer_q - 8'd1;
            end
        end
    end

    // Lock state registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= StOpen;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign LOCKED = (state_q != StOpen);
`else
    assign LOCKED = 1'b0;
`endif

    // Divider and bus output registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            div_q   <= 8'd0;
            clken_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 5'd0;
            data_q  <= 8'd0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            div_q   <= div_d;
            clken_q <= clken_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign A_READY = a_rdy;
    assign B_READY = b_rdy;
    assign CLKEN   = clken_q;
    assign WR      = wr_q;
    assign ADDR    = addr_q;
    assign DATA    = data_q;
    assign GRANT   = grant_q;

endmodule

// File: tb/tb_sid_bus_arbiter.sv
// Directed testbench for sid_bus_arbiter (CLK_DIV=12, LOCK_TIMEOUT=15).
// Lock scenarios are checked when SID_ARB_ATOMIC_EN is defined; otherwise the
// same addresses are expected to arbitrate as pure round-robin.
module tb_sid_bus_arbiter;

`ifdef SID_ARB_ATOMIC_EN
    localparam bit Atomic = 1'b1;
`else
    localparam bit Atomic = 1'b0;
`endif

    logic       CLK;
    logic       RESETn;
    logic       A_VALID, B_VALID;
    logic       A_READY, B_READY;
    logic [4:0] A_ADDR, B_ADDR;
    logic [7:0] A_DATA, B_DATA;
    logic       CLKEN, WR, GRANT, LOCKED;
    logic [4:0] ADDR;
    logic [7:0] DATA;

    int errors = 0;
    int checks = 0;

    sid_bus_arbiter #(
        .CLK_DIV     (12),
        .LOCK_TIMEOUT(15)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .A_VALID(A_VALID),
        .A_READY(A_READY),
        .A_ADDR (A_ADDR),
        .A_DATA (A_DATA),
        .B_VALID(B_VALID),
        .B_READY(B_READY),
        .B_ADDR (B_ADDR),
        .B_DATA (B_DATA),
        .CLKEN  (CLKEN),
        .WR     (WR),
        .ADDR   (ADDR),
        .DATA   (DATA),
        .GRANT  (GRANT),
        .LOCKED (LOCKED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle registered outputs.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_bus(input string tag, input logic wr, input logic [4:0] a,
                           input logic [7:0] d, input logic g);
        chk({tag, ".wr"}, 32'(WR), 32'(wr));
        chk({tag, ".addr"}, 32'(ADDR), 32'(a));
        chk({tag, ".data"}, 32'(DATA), 32'(d));
        chk({tag, ".grant"}, 32'(GRANT), 32'(g));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETn  = 1'b0;
        A_VALID = 1'b0;
        B_VALID = 1'b0;
        A_ADDR  = 5'd0;
        B_ADDR  = 5'd0;
        A_DATA  = 8'd0;
        B_DATA  = 8'd0;

        // Reset values.
        #3;
        chk_bus("rst", 1'b0, 5'd0, 8'd0, 1'b0);
        chk("rst.locked", 32'(LOCKED), 32'd0);
        chk("rst.clken", 32'(CLKEN), 32'd0);
        chk("rst.a_ready", 32'(A_READY), 32'd0);
        chk("rst.b_ready", 32'(B_READY), 32'd0);
        #9;
        RESETn = 1'b1;

        // Idle: CLKEN high after every 12th edge, one cycle wide; bus stays quiet.
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk("idle.clken", 32'(CLKEN), 32'((k % 12) == 0));
            chk("idle.wr", 32'(WR), 32'd0);
        end
        chk("idle.addr", 32'(ADDR), 32'd0);
        chk("idle.data", 32'(DATA), 32'd0);

        // A alone writes 4/0x41.
        A_VALID = 1'b1;
        A_ADDR  = 5'd4;
        A_DATA  = 8'h41;
        #1;
        chk("a1.a_ready", 32'(A_READY), 32'd1);
        chk("a1.b_ready", 32'(B_READY), 32'd0);
        tick();
        A_VALID = 1'b0;
        chk_bus("a1.bus", 1'b1, 5'd4, 8'h41, 1'b0);
        tick();
        chk_bus("a1.hold", 1'b0, 5'd4, 8'h41, 1'b0);

        // B alone writes 21/0x55 (filter range); pointer becomes last=B.
        B_VALID = 1'b1;
        B_ADDR  = 5'd21;
        B_DATA  = 8'h55;
        #1;
        chk("b1.b_ready", 32'(B_READY), 32'd1);
        chk("b1.a_ready", 32'(A_READY), 32'd0);
        tick();
        B_VALID = 1'b0;
        chk_bus("b1.bus", 1'b1, 5'd21, 8'h55, 1'b1);
        chk("b1.locked", 32'(LOCKED), 32'd0);
        tick();
        chk("b1.wr_off", 32'(WR), 32'd0);

        // Both hold non-trigger writes: A,B,A,B with continuous WR.
        A_VALID = 1'b1;
        A_ADDR  = 5'd5;
        A_DATA  = 8'hA5;
        B_VALID = 1'b1;
        B_ADDR  = 5'd12;
        B_DATA  = 8'hB6;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr.a_ready", 32'(A_READY), 32'((i % 2) == 0));
            chk("rr.b_ready", 32'(B_READY), 32'((i % 2) == 1));
            tick();
            if ((i % 2) == 0) chk_bus("rr.bus", 1'b1, 5'd5, 8'hA5, 1'b0);
            else              chk_bus("rr.bus", 1'b1, 5'd12, 8'hB6, 1'b1);
        end
        A_VALID = 1'b0;
        B_VALID = 1'b0;
        tick();
        chk("rr.wr_off", 32'(WR), 32'd0);

`ifdef SID_ARB_ATOMIC_EN
        // A writes 7 (trigger), stalls 3 cycles, then writes 8; B valid throughout.
        A_VALID = 1'b1;
        A_ADDR  = 5'd7;
        A_DATA  = 8'h07;
        B_VALID = 1'b1;
        B_ADDR  = 5'd12;
        B_DATA  = 8'hB6;
        #1;
        chk("lk.a_ready", 32'(A_READY), 32'd1);
        tick();
        A_VALID = 1'b0;
        chk_bus("lk.bus7", 1'b1, 5'd7, 8'h07, 1'b0);
        chk("lk.locked1", 32'(LOCKED), 32'd1);
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("lk.stall_b_ready", 32'(B_READY), 32'd0);
            tick();
            chk("lk.stall_locked", 32'(LOCKED), 32'd1);
            chk("lk.stall_wr", 32'(WR), 32'd0);
        end
        A_VALID = 1'b1;
        A_ADDR  = 5'd8;
        A_DATA  = 8'h08;
        #1;
        chk("lk.a8_ready", 32'(A_READY), 32'd1);
        chk("lk.a8_b_ready", 32'(B_READY), 32'd0);
        tick();
        A_VALID = 1'b0;
        chk_bus("lk.bus8", 1'b1, 5'd8, 8'h08, 1'b0);
        chk("lk.unlocked", 32'(LOCKED), 32'd0);
        #1;
        chk("lk.b_ready", 32'(B_READY), 32'd1);
        tick();
        B_VALID = 1'b0;
        chk_bus("lk.busb", 1'b1, 5'd12, 8'hB6, 1'b1);
        tick();

        // A writes 0 then drops; B blocked 15 cycles, granted in the 16th.
        A_VALID = 1'b1;
        A_ADDR  = 5'd0;
        A_DATA  = 8'h10;
        B_VALID = 1'b1;
        #1;
        chk("to.a_ready", 32'(A_READY), 32'd1);
        tick();
        A_VALID = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            #1;
            chk("to.b_blocked", 32'(B_READY), 32'd0);
            chk("to.locked", 32'(LOCKED), 32'd1);
            tick();
        end
        #1;
        chk("to.b_ready", 32'(B_READY), 32'd1);
        chk("to.locked_off", 32'(LOCKED), 32'd0);
        tick();
        B_VALID = 1'b0;
        chk_bus("to.busb", 1'b1, 5'd12, 8'hB6, 1'b1);
        tick();
`else
        // Trigger addresses do not hold the bus: B wins right after A's write to 7.
        A_VALID = 1'b1;
        A_ADDR  = 5'd7;
        A_DATA  = 8'h07;
        B_VALID = 1'b1;
        B_ADDR  = 5'd12;
        B_DATA  = 8'hB6;
        #1;
        chk("nl.a_ready", 32'(A_READY), 32'd1);
        tick();
        A_ADDR = 5'd8;
        A_DATA = 8'h08;
        chk_bus("nl.bus7", 1'b1, 5'd7, 8'h07, 1'b0);
        chk("nl.locked", 32'(LOCKED), 32'd0);
        #1;
        chk("nl.b_ready", 32'(B_READY), 32'd1);
        chk("nl.a_blocked", 32'(A_READY), 32'd0);
        tick();
        B_VALID = 1'b0;
        chk_bus("nl.busb", 1'b1, 5'd12, 8'hB6, 1'b1);
        #1;
        chk("nl.a8_ready", 32'(A_READY), 32'd1);
        tick();
        A_VALID = 1'b0;
        chk_bus("nl.bus8", 1'b1, 5'd8, 8'h08, 1'b0);
        tick();
`endif

        // B writes trigger 2 (enters LOCK_B when atomic), then reset mid-lock.
        B_VALID = 1'b1;
        B_ADDR  = 5'd2;
        B_DATA  = 8'h22;
        #1;
        chk("rl.b_ready", 32'(B_READY), 32'd1);
        tick();
        B_VALID = 1'b0;
        A_VALID = 1'b1;
        A_ADDR  = 5'd5;
        A_DATA  = 8'hA5;
        chk_bus("rl.bus", 1'b1, 5'd2, 8'h22, 1'b1);
        chk("rl.locked", 32'(LOCKED), 32'(Atomic));
        #1;
        chk("rl.a_ready", 32'(A_READY), 32'(!Atomic));
        RESETn = 1'b0;
        #1;
        chk_bus("rl.rst", 1'b0, 5'd0, 8'd0, 1'b0);
        chk("rl.rst_locked", 32'(LOCKED), 32'd0);
        chk("rl.rst_clken", 32'(CLKEN), 32'd0);
        #1;
        RESETn = 1'b1;
        // First tie after reset goes to A.
        B_VALID = 1'b1;
        B_ADDR  = 5'd12;
        B_DATA  = 8'hB6;
        #1;
        chk("rt.a_ready", 32'(A_READY), 32'd1);
        chk("rt.b_ready", 32'(B_READY), 32'd0);
        tick();
        A_VALID = 1'b0;
        chk_bus("rt.bus", 1'b1, 5'd5, 8'hA5, 1'b0);
        chk("rt.locked", 32'(LOCKED), 32'd0);
        #1;
        chk("rt.b_next", 32'(B_READY), 32'd1);
        tick();
        B_VALID = 1'b0;
        chk_bus("rt.busb", 1'b1, 5'd12, 8'hB6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
